// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the word-addressed PC, drives instruction memory,
// and loads the IF/ID pipeline register with stall, redirect/flush and HALT handling.
module fetch_stage #(
  parameter int          PC_W        = 11,
  parameter int          INSTR_W     = 32,
  parameter logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               resume,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    if_id_pc_plus1,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [INSTR_W-1:0] HALT_WORD = HALT_OPCODE[INSTR_W-1:0];
  localparam logic [INSTR_W-1:0] NOP_WORD  = NOP_INSTR[INSTR_W-1:0];

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt;
  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    pc1_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic               valid_nxt;
  logic [31:0]        count_nxt;

  // PC arithmetic stays in PC_W bits so the top word wraps to 0.
  assign pc_plus1  = pc + 1'b1;
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      pc             <= '0;
      if_id_pc_plus1 <= '0;
      if_id_instr    <= NOP_WORD;
      if_id_valid    <= 1'b0;
      fetch_count    <= '0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      if_id_pc_plus1 <= pc1_nxt;
      if_id_instr    <= instr_nxt;
      if_id_valid    <= valid_nxt;
      fetch_count    <= count_nxt;
    end
  end

  // Priority: branch_taken > jump (RUN only) > stall > HALT hold > normal fetch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pc1_nxt   = if_id_pc_plus1;
    instr_nxt = if_id_instr;
    valid_nxt = if_id_valid;
    count_nxt = fetch_count;

    if (branch_taken) begin
      // A taken branch squashes the path the halt word came from.
      pc_nxt    = branch_target;
      instr_nxt = NOP_WORD;
      valid_nxt = 1'b0;
      state_nxt = RUN;
    end else if (jump && state == RUN) begin
      pc_nxt    = jump_target;
      instr_nxt = NOP_WORD;
      valid_nxt = 1'b0;
    end else if (stall) begin
      // Everything holds, including a pending resume.
    end else if (state == HALT) begin
      instr_nxt = NOP_WORD;
      valid_nxt = 1'b0;
      if (resume) begin
        pc_nxt    = pc_plus1;
        state_nxt = RUN;
      end
    end else begin
      pc1_nxt   = pc_plus1;
      instr_nxt = imem_data;
      valid_nxt = 1'b1;
      count_nxt = fetch_count + 32'd1;
      if (imem_data == HALT_WORD) begin
        state_nxt = HALT;
      end else begin
        pc_nxt = pc_plus1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem returns addr+100 except an optional halt word.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken, jump, resume;
  logic [10:0] branch_target, jump_target;
  logic [10:0] imem_addr;
  logic [31:0] imem_data;
  logic [10:0] if_id_pc_plus1;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic        halt_en;
  logic [10:0] halt_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (halt_en && imem_addr == halt_addr) imem_data = 32'hFFFF_FFFF;
    else                                   imem_data = {21'd0, imem_addr} + 32'd100;
  end

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .resume         (resume),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [10:0] pc1,
                          input logic [31:0] instr, input logic valid);
    check({tag, "_pc1"},   {21'd0, if_id_pc_plus1}, {21'd0, pc1});
    check({tag, "_instr"}, if_id_instr, instr);
    check({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; resume = 1'b0;
    branch_target = '0; jump_target = '0; halt_en = 1'b0; halt_addr = 11'd9;
    #12;
    check("rst_addr", {21'd0, imem_addr}, 32'd0);
    check_if("rst", 11'd0, 32'd0, 1'b0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    step();
    reset = 1'b0;

    // Sequential fetch from 0.
    check("seq_addr0", {21'd0, imem_addr}, 32'd0);
    step();
    check_if("seq1", 11'd1, 32'd100, 1'b1);
    check("seq_addr1", {21'd0, imem_addr}, 32'd1);
    step();
    check_if("seq2", 11'd2, 32'd101, 1'b1);
    check("seq_addr2", {21'd0, imem_addr}, 32'd2);
    step();
    check_if("seq3", 11'd3, 32'd102, 1'b1);
    check("seq_addr3", {21'd0, imem_addr}, 32'd3);
    check("seq_count", fetch_count, 32'd3);

    // Stall for two cycles at pc=5.
    step(); step();
    check("pre_stall_addr", {21'd0, imem_addr}, 32'd5);
    stall = 1'b1;
    step(); step();
    check("stall_addr", {21'd0, imem_addr}, 32'd5);
    check_if("stall", 11'd5, 32'd104, 1'b1);
    check("stall_count", fetch_count, 32'd5);
    stall = 1'b0;
    step();
    check_if("post_stall", 11'd6, 32'd105, 1'b1);
    check("post_stall_addr", {21'd0, imem_addr}, 32'd6);
    check("post_stall_count", fetch_count, 32'd6);

    // Branch beats jump and stall in the same cycle.
    branch_taken = 1'b1; branch_target = 11'h200;
    jump = 1'b1; jump_target = 11'h123; stall = 1'b1;
    step();
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
    check("br_addr", {21'd0, imem_addr}, 32'h200);
    check_if("br", 11'd6, 32'd0, 1'b0);
    check("br_count", fetch_count, 32'd6);

    // PC wrap at 0x7FF.
    jump = 1'b1; jump_target = 11'h7FF;
    step();
    jump = 1'b0;
    check("jmp_addr", {21'd0, imem_addr}, 32'h7FF);
    check("jmp_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    check_if("wrap", 11'h000, 32'h863, 1'b1);
    check("wrap_addr", {21'd0, imem_addr}, 32'd0);
    check("wrap_count", fetch_count, 32'd7);

    // Halt at address 9, then resume.
    halt_en = 1'b1;
    jump = 1'b1; jump_target = 11'd9;
    step();
    jump = 1'b0;
    step();
    check_if("halt_word", 11'd10, 32'hFFFF_FFFF, 1'b1);
    check("halt_addr", {21'd0, imem_addr}, 32'd9);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_count", fetch_count, 32'd8);
    step();
    check_if("halt_bubble", 11'd10, 32'd0, 1'b0);
    check("halt_hold_addr", {21'd0, imem_addr}, 32'd9);
    check("halt_hold_count", fetch_count, 32'd8);
    jump = 1'b1; jump_target = 11'h050;
    step();
    jump = 1'b0;
    check("halt_jmp_addr", {21'd0, imem_addr}, 32'd9);
    check("halt_jmp_flag", {31'd0, halted}, 32'd1);
    resume = 1'b1; stall = 1'b1;
    step();
    check("halt_stall_res_addr", {21'd0, imem_addr}, 32'd9);
    check("halt_stall_res_flag", {31'd0, halted}, 32'd1);
    stall = 1'b0;
    step();
    resume = 1'b0;
    check("resume_addr", {21'd0, imem_addr}, 32'd10);
    check("resume_flag", {31'd0, halted}, 32'd0);
    check("resume_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    check_if("after_resume", 11'd11, 32'd110, 1'b1);
    check("after_resume_count", fetch_count, 32'd9);

    // Halt again, leave via branch to 3.
    jump = 1'b1; jump_target = 11'd9;
    step();
    jump = 1'b0;
    step();
    check("halt2_flag", {31'd0, halted}, 32'd1);
    check("halt2_count", fetch_count, 32'd10);
    branch_taken = 1'b1; branch_target = 11'd3; resume = 1'b1;
    step();
    branch_taken = 1'b0; resume = 1'b0;
    check("halt_br_addr", {21'd0, imem_addr}, 32'd3);
    check("halt_br_flag", {31'd0, halted}, 32'd0);
    check("halt_br_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    check_if("after_halt_br", 11'd4, 32'd103, 1'b1);
    check("after_halt_br_count", fetch_count, 32'd11);

    // Asynchronous reset while halted, between clock edges.
    jump = 1'b1; jump_target = 11'd9;
    step();
    jump = 1'b0;
    step();
    check("halt3_flag", {31'd0, halted}, 32'd1);
    check("halt3_addr", {21'd0, imem_addr}, 32'd9);
    #1;
    reset = 1'b1;
    #1;
    check("arst_addr", {21'd0, imem_addr}, 32'd0);
    check_if("arst", 11'd0, 32'd0, 1'b0);
    check("arst_flag", {31'd0, halted}, 32'd0);
    check("arst_count", fetch_count, 32'd0);
    step();
    reset = 1'b0;
    check("post_rst_addr", {21'd0, imem_addr}, 32'd0);
    step();
    check_if("post_rst", 11'd1, 32'd100, 1'b1);
    check("post_rst_count", fetch_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
